// File: rtl/i2c_txn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_txn_ctrl
//  Function : Single-register I2C master. Runs one register write
//             (START, addr+W, index, data, STOP) or one register read
//             (START, addr+W, index, RESTART, addr+R, data, master NACK,
//             STOP) per accepted request, driving open-drain enables.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_txn_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_index,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam logic [15:0] TICK_MAX  = 16'(CLK_DIV - 1);
    // Which byte the current TXBIT/ACKCHK pass belongs to
    localparam logic [1:0]  PH_ADDR_W = 2'd0;
    localparam logic [1:0]  PH_INDEX  = 2'd1;
    localparam logic [1:0]  PH_WDATA  = 2'd2;
    localparam logic [1:0]  PH_ADDR_R = 2'd3;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        START   = 4'd1,
        TXBIT   = 4'd2,
        ACKCHK  = 4'd3,
        RESTART = 4'd4,
        RXBIT   = 4'd5,
        MNACK   = 4'd6,
        STOP    = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] tick;
    logic [1:0]  qtr;
    logic [2:0]  bit_idx;
    logic [1:0]  phase;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  index;
    logic [7:0]  wdata;
    logic [7:0]  tx_sh;
    logic [7:0]  rx_sh;
    logic        nack;
    logic        qtr_end;
    logic        last_qtr;
    logic        sample;
    logic        step;

    // Quarter boundary and the SDA sample point (last clk of quarter 2)
    assign qtr_end = (tick == TICK_MAX);
    assign sample  = qtr_end && (qtr == 2'd2);
    assign step    = qtr_end && last_qtr;

    // State register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and line/handshake outputs
    always_comb begin
        state_nx  = state;
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        last_qtr  = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = START;
            end
            START: begin
                sda_oe   = 1'b1;
                scl_oe   = (qtr == 2'd1);
                last_qtr = (qtr == 2'd1);
                if (step) state_nx = TXBIT;
            end
            TXBIT: begin
                scl_oe   = (qtr == 2'd0) || (qtr == 2'd3);
                sda_oe   = ~tx_sh[7];
                last_qtr = (qtr == 2'd3);
                if (step && bit_idx == 3'd7) state_nx = ACKCHK;
            end
            ACKCHK: begin
                scl_oe   = (qtr == 2'd0) || (qtr == 2'd3);
                last_qtr = (qtr == 2'd3);
                if (step) begin
                    if (nack) begin
                        state_nx = STOP;
                    end else begin
                        case (phase)
                            PH_ADDR_W: state_nx = TXBIT;
                            PH_INDEX:  state_nx = rw ? RESTART : TXBIT;
                            PH_WDATA:  state_nx = STOP;
                            default:   state_nx = RXBIT;
                        endcase
                    end
                end
            end
            RESTART: begin
                scl_oe   = (qtr == 2'd0) || (qtr == 2'd3);
                sda_oe   = (qtr == 2'd2) || (qtr == 2'd3);
                last_qtr = (qtr == 2'd3);
                if (step) state_nx = TXBIT;
            end
            RXBIT: begin
                scl_oe   = (qtr == 2'd0) || (qtr == 2'd3);
                last_qtr = (qtr == 2'd3);
                if (step && bit_idx == 3'd7) state_nx = MNACK;
            end
            MNACK: begin
                scl_oe   = (qtr == 2'd0) || (qtr == 2'd3);
                last_qtr = (qtr == 2'd3);
                if (step) state_nx = STOP;
            end
            STOP: begin
                scl_oe   = (qtr == 2'd0);
                sda_oe   = (qtr != 2'd2);
                last_qtr = (qtr == 2'd2);
                if (step) state_nx = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Timing counters, request capture, shift registers and response hold
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            tick      <= 16'd0;
            qtr       <= 2'd0;
            bit_idx   <= 3'd0;
            phase     <= PH_ADDR_W;
            rw        <= 1'b0;
            addr      <= 7'd0;
            index     <= 8'd0;
            wdata     <= 8'd0;
            tx_sh     <= 8'd0;
            rx_sh     <= 8'd0;
            nack      <= 1'b0;
            rsp_rdata <= 8'd0;
            rsp_nack  <= 1'b0;
        end else begin
            if (state == IDLE || state == DONE) begin
                tick <= 16'd0;
                qtr  <= 2'd0;
            end else if (qtr_end) begin
                tick <= 16'd0;
                qtr  <= last_qtr ? 2'd0 : qtr + 2'd1;
            end else begin
                tick <= tick + 16'd1;
            end

            if (state == IDLE && req_valid) begin
                rw      <= req_rw;
                addr    <= req_addr;
                index   <= req_index;
                wdata   <= req_wdata;
                tx_sh   <= {req_addr, 1'b0};
                phase   <= PH_ADDR_W;
                bit_idx <= 3'd0;
                nack    <= 1'b0;
                rx_sh   <= 8'd0;
            end

            if (sample && state == ACKCHK && sda_in) nack <= 1'b1;
            if (sample && state == RXBIT) rx_sh <= {rx_sh[6:0], sda_in};

            if (step) begin
                case (state)
                    TXBIT: begin
                        bit_idx <= bit_idx + 3'd1;
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end
                    ACKCHK: begin
                        if (!nack && phase == PH_ADDR_W) begin
                            tx_sh <= index;
                            phase <= PH_INDEX;
                        end else if (!nack && phase == PH_INDEX && !rw) begin
                            tx_sh <= wdata;
                            phase <= PH_WDATA;
                        end
                    end
                    RESTART: begin
                        tx_sh <= {addr, 1'b1};
                        phase <= PH_ADDR_R;
                    end
                    RXBIT: bit_idx <= bit_idx + 3'd1;
                    STOP: begin
                        rsp_rdata <= (rw && !nack) ? rx_sh : 8'd0;
                        rsp_nack  <= nack;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_i2c_txn_ctrl
//  Function : Scoreboard bench for i2c_txn_ctrl with a behavioural I2C slave
//             that ACKs, returns read data and decodes the SDA byte stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_txn_ctrl;

    localparam int CLK_DIV = 4;

    typedef struct {
        logic [7:0] rdata;
        logic       nack;
        int         lat;
        int         starts;
        int         stops;
    } rsp_t;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = 7'd0;
    logic [7:0] req_index = 8'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_in;
    logic       slave_pull = 1'b0;

    logic       present = 1'b1;
    logic [7:0] slave_data = 8'd0;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   rsp_cnt = 0;
    int   tot_acc = 0;
    int   acc_since = 0;
    int   last_rsp_cyc = -1;
    bit   b2b_mode = 1'b0;
    int   starts_seen = 0;
    int   stops_seen = 0;

    rsp_t       exp_q[$];
    logic [7:0] byte_q[$];
    int         acc_q[$];

    assign sda_in = ~(sda_oe | slave_pull);

    i2c_txn_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_index (req_index),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    // Clock and free-running cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Accept recorder and response scoreboard
    always @(negedge clk) begin
        if (RST) begin
            acc_q.delete();
            acc_since = 0;
        end else begin
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc);
                acc_since++;
                tot_acc++;
                if (b2b_mode && last_rsp_cyc >= 0)
                    chk("b2b_accept_cycle", cyc, last_rsp_cyc + 1);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_nack", rsp_nack, e.nack);
                    if (acc_q.size() == 0) chk("rsp_without_accept", 1, 0);
                    else chk("rsp_latency", cyc - acc_q.pop_front(), e.lat);
                    chk("accepts_per_txn", acc_since, 1);
                    chk("start_conditions", starts_seen, e.starts);
                    chk("stop_conditions", stops_seen, e.stops);
                end
                starts_seen  = 0;
                stops_seen   = 0;
                acc_since    = 0;
                last_rsp_cyc = cyc;
                rsp_cnt++;
            end
        end
    end

    // Behavioural slave: START/STOP detection, byte decode, ACK and read data
    always @(negedge clk) begin
        static logic       prev_scl = 1'b1;
        static logic       prev_sda = 1'b1;
        static int         bitc = 0;
        static logic [7:0] sh = 8'd0;
        static bit         addr_byte = 1'b0;
        static bit         pend_tx = 1'b0;
        static bit         tx_mode = 1'b0;
        logic scl;
        logic sda;
        scl = ~scl_oe;
        sda = sda_in;
        if (RST) begin
            bitc = 0; addr_byte = 1'b0; pend_tx = 1'b0; tx_mode = 1'b0;
            slave_pull = 1'b0; starts_seen = 0; stops_seen = 0;
            scl = 1'b1; sda = 1'b1;
        end else if (prev_scl && scl && prev_sda && !sda) begin
            starts_seen++;
            bitc = 0; addr_byte = 1'b1; pend_tx = 1'b0; tx_mode = 1'b0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            stops_seen++;
            bitc = 0; pend_tx = 1'b0; tx_mode = 1'b0; slave_pull = 1'b0;
        end else if (!prev_scl && scl) begin
            if (bitc < 8) sh = {sh[6:0], sda};
            else if (bitc == 8 && tx_mode) chk("master_nack_bit", sda, 1);
            bitc++;
        end else if (prev_scl && !scl) begin
            if (bitc == 8) begin
                if (byte_q.size() == 0) chk("unexpected_byte", 1, 0);
                else chk("sda_byte", sh, byte_q.pop_front());
                slave_pull = tx_mode ? 1'b0 : present;
                if (addr_byte && sh[0] && present) pend_tx = 1'b1;
                addr_byte = 1'b0;
            end else if (bitc == 9) begin
                bitc = 0;
                slave_pull = 1'b0;
                if (pend_tx) begin
                    tx_mode = 1'b1;
                    pend_tx = 1'b0;
                    slave_pull = ~slave_data[7];
                end else begin
                    tx_mode = 1'b0;
                end
            end else if (tx_mode && bitc >= 1 && bitc <= 7) begin
                slave_pull = ~slave_data[7 - bitc];
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    task automatic push_bytes(input int n, input logic [7:0] b0, b1, b2, b3);
        if (n > 0) byte_q.push_back(b0);
        if (n > 1) byte_q.push_back(b1);
        if (n > 2) byte_q.push_back(b2);
        if (n > 3) byte_q.push_back(b3);
    endtask

    task automatic push_rsp(input logic [7:0] rd, input logic nk, input int lat, st);
        rsp_t e;
        e.rdata = rd; e.nack = nk; e.lat = lat; e.starts = st; e.stops = 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int k;
        k = 0;
        while (rsp_cnt < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (rsp_cnt < target) chk("rsp_timeout", rsp_cnt, target);
    endtask

    task automatic drive_req(input logic rw, input logic [6:0] a, input logic [7:0] idx, wd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_index = idx; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic txn(input logic rw, input logic [6:0] a, input logic [7:0] idx, wd,
                       input bit pres, input logic [7:0] sdat,
                       input int nb, input logic [7:0] b0, b1, b2, b3,
                       input logic [7:0] rd, input logic nk, input int lat, st);
        int n0;
        n0 = rsp_cnt;
        present = pres;
        slave_data = sdat;
        push_bytes(nb, b0, b1, b2, b3);
        push_rsp(rd, nk, lat, st);
        drive_req(rw, a, idx, wd);
        wait_rsp(n0 + 1, 1000);
        repeat (3) @(posedge clk);
        #1;
        chk("rdata_hold", rsp_rdata, rd);
        chk("nack_hold", rsp_nack, nk);
    endtask

    initial begin
        int n0;
        int a0;
        int k;
        RST = 1'b1;
        #1;
        chk("reset_scl_oe", scl_oe, 0);
        chk("reset_sda_oe", sda_oe, 0);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_nack", rsp_nack, 0);
        RST = 1'b0;
        repeat (2) @(posedge clk);

        // Write with ACK, read with ACK, both against an absent slave
        txn(1'b0, 7'h55, 8'h01, 8'hA5, 1'b1, 8'h00, 3, 8'hAA, 8'h01, 8'hA5, 8'h00,
            8'h00, 1'b0, 113*CLK_DIV+1, 1);
        txn(1'b1, 7'h55, 8'h01, 8'h00, 1'b1, 8'h5A, 4, 8'hAA, 8'h01, 8'hAB, 8'h5A,
            8'h5A, 1'b0, 153*CLK_DIV+1, 2);
        txn(1'b0, 7'h55, 8'h01, 8'hA5, 1'b0, 8'h00, 1, 8'hAA, 8'h00, 8'h00, 8'h00,
            8'h00, 1'b1, 41*CLK_DIV+1, 1);
        txn(1'b1, 7'h12, 8'h34, 8'h00, 1'b0, 8'h00, 1, 8'h24, 8'h00, 8'h00, 8'h00,
            8'h00, 1'b1, 41*CLK_DIV+1, 1);
        txn(1'b0, 7'h12, 8'hFF, 8'h3C, 1'b1, 8'h00, 3, 8'h24, 8'hFF, 8'h3C, 8'h00,
            8'h00, 1'b0, 113*CLK_DIV+1, 1);
        txn(1'b1, 7'h7F, 8'h80, 8'h00, 1'b1, 8'hC3, 4, 8'hFE, 8'h80, 8'hFF, 8'hC3,
            8'hC3, 1'b0, 153*CLK_DIV+1, 2);

        // req_valid held high across two back-to-back writes
        present = 1'b1;
        n0 = rsp_cnt;
        a0 = tot_acc;
        push_bytes(3, 8'hAA, 8'h01, 8'hA5, 8'h00);
        push_bytes(3, 8'hAA, 8'h01, 8'hA5, 8'h00);
        push_rsp(8'h00, 1'b0, 113*CLK_DIV+1, 1);
        push_rsp(8'h00, 1'b0, 113*CLK_DIV+1, 1);
        b2b_mode = 1'b1;
        last_rsp_cyc = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h55; req_index = 8'h01; req_wdata = 8'hA5;
        k = 0;
        while (tot_acc < a0 + 2 && k < 1500) begin
            @(posedge clk); #1;
            k++;
        end
        req_valid = 1'b0;
        chk("b2b_two_accepts", tot_acc - a0, 2);
        wait_rsp(n0 + 2, 1500);
        b2b_mode = 1'b0;

        // Reset pulse during the index byte, then a normal write
        n0 = rsp_cnt;
        present = 1'b1;
        push_bytes(1, 8'hAA, 8'h00, 8'h00, 8'h00);
        drive_req(1'b0, 7'h55, 8'h01, 8'hA5);
        repeat (198) @(posedge clk);
        @(negedge clk); #2;
        RST = 1'b1;
        #1;
        chk("midrst_scl_oe", scl_oe, 0);
        chk("midrst_sda_oe", sda_oe, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;
        chk("midrst_bytes_seen", byte_q.size(), 0);
        repeat (20) @(posedge clk);
        chk("midrst_no_rsp", rsp_cnt, n0);
        txn(1'b0, 7'h55, 8'h01, 8'hA5, 1'b1, 8'h00, 3, 8'hAA, 8'h01, 8'hA5, 8'h00,
            8'h00, 1'b0, 113*CLK_DIV+1, 1);

        repeat (10) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("bytes_drained", byte_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_txn_ctrl.md
I2C_TXN_CTRL -- requirements
Module: i2c_txn_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per quarter SCL period; legal range 2..65535.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  transaction request.
REQ-005 SHALL have port req_ready  out  1  controller can accept a request.
REQ-006 SHALL have port req_rw  in  1  0 = register write, 1 = register read.
REQ-007 SHALL have port req_addr  in  7  slave address.
REQ-008 SHALL have port req_index  in  8  register index.
REQ-009 SHALL have port req_wdata  in  8  write data; ignored for reads.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle transaction-complete pulse.
REQ-011 SHALL have port rsp_rdata  out  8  read data; valid with rsp_valid.
REQ-012 SHALL have port rsp_nack  out  1  a slave ACK slot was NACKed; valid with rsp_valid.
REQ-013 SHALL have port scl_oe  out  1  1 = pull SCL low, 0 = release.
REQ-014 SHALL have port sda_oe  out  1  1 = pull SDA low, 0 = release.
REQ-015 SHALL have port sda_in  in  1  sampled SDA line level.

Function
REQ-016 SHALL accept a request in the cycle where req_valid && req_ready, capturing req_rw, req_addr, req_index and req_wdata.
REQ-017 SHALL drive req_ready high only in IDLE; req_valid is ignored outside IDLE.
REQ-018 SHALL use a quarter-tick counter of CLK_DIV cycles, started in the cycle after accept.
REQ-019 SHALL use states IDLE, START, TXBIT, ACKCHK, RESTART, RXBIT, MNACK, STOP, DONE.
REQ-020 START sequence, 2 quarters: q0 sda_oe=1 with SCL released; q1 scl_oe=1.
REQ-021 Each bit SHALL take 4 quarters:
- q0: scl_oe=1, SDA set up.
- q1, q2: SCL released.
- sda_in sampled in the last clk of q2.
- q3: scl_oe=1.
REQ-022 TXBIT SHALL send MSB first; for data bit d, sda_oe=~d. During ACKCHK, RXBIT and the unused bits, sda_oe=0.
REQ-023 Write sequence SHALL be: START, {addr,0}, ACKCHK, index, ACKCHK, wdata, ACKCHK, STOP.
REQ-024 Read sequence SHALL be: START, {addr,0}, ACKCHK, index, ACKCHK, RESTART, {addr,1}, ACKCHK, 8 RXBIT, MNACK, STOP.
REQ-025 RESTART SHALL take 4 quarters:
- q0: scl_oe=1, sda_oe=0.
- q1: SCL released.
- q2, q3: the START pattern.
REQ-026 MNACK SHALL be one bit slot with sda_oe=0, i.e. the master NACKs the final read byte.
REQ-027 STOP, 3 quarters: q0 scl_oe=1, sda_oe=1; q1 SCL released; q2 SDA released.
REQ-028 ACKCHK sampling 1 SHALL set the nack flag; the controller completes that bit's q3, skips all remaining bits and enters STOP.
REQ-029 DONE SHALL last 1 cycle with rsp_valid=1, then return to IDLE.
- rsp_rdata = received byte; 0 on NACK or write.
- rsp_nack = nack flag.
REQ-030 Write with no NACK: rsp_valid SHALL assert exactly 113*CLK_DIV+1 cycles after the accept cycle.
REQ-031 Read with no NACK: rsp_valid SHALL assert exactly 153*CLK_DIV+1 cycles after the accept cycle.
REQ-032 SDA SHALL change only while SCL is held low, except during START, RESTART q2 and STOP q2.
REQ-033 rsp_rdata and rsp_nack SHALL hold their values until the next DONE.

Reset
REQ-034 While RST=1, all state SHALL clear immediately with no clock needed:
- state=IDLE;
- scl_oe=0, sda_oe=0;
- req_ready=1;
- rsp_valid=0, rsp_rdata=0, rsp_nack=0.
REQ-035 RST asserted mid-transaction SHALL release both lines at once and emit no rsp_valid; the first request after RST deassertion SHALL be accepted normally.

Verification
REQ-036 CLK_DIV=4, slave ACKs, write addr 0x55 idx 0x01 data 0xA5:
- SDA bit stream 0xAA, 0x01, 0xA5;
- rsp_valid at accept+453 cycles, rsp_nack=0.
REQ-037 Read addr 0x55 idx 0x01, slave returns 0x5A:
- bytes 0xAA, 0x01, RESTART, 0xAB observed;
- master NACK on the data byte;
- rsp_rdata=0x5A at accept+613 cycles.
REQ-038 Slave absent (sda_in stays 1), write:
- STOP directly after the first ACK slot;
- rsp_nack=1, rsp_rdata=0.
REQ-039 req_valid held high continuously: exactly one accept per transaction, and a new accept in the cycle after rsp_valid.
REQ-040 RST pulsed during the index byte:
- scl_oe=0 and sda_oe=0 in the same cycle;
- no rsp_valid;
- next write completes per REQ-036.
REQ-041 A protocol checker SHALL flag any SDA edge while SCL is high outside START, RESTART and STOP, across all the above scenarios.
